// File: rtl/pong_state_reader.sv
// Steps a pong game core through its four fields, one field per game_clk period.
// Each frame of four bytes is published as a snapshot with a valid/ready handshake.
module pong_state_reader #(
    parameter int unsigned STEP_DIV = 16,
    parameter int unsigned SETTLE   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        game_clk,
    output logic [1:0]  game_sel,
    input  logic [7:0]  game_data,
    output logic [7:0]  snap_ball_x,
    output logic [7:0]  snap_ball_y,
    output logic [7:0]  snap_left,
    output logic [7:0]  snap_right,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic        overrun,
    output logic [15:0] step_count
);

    localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HALF  = STEP_DIV / 2;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF);

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             step_end_c;
    logic             capture_c;
    logic             frame_done_c;
    logic             load_c;
    logic             game_clk_next_c;

    // Bytes 0..2 of the frame in progress; byte 3 goes straight to the snapshot.
    logic [7:0] shadow_x;
    logic [7:0] shadow_y;
    logic [7:0] shadow_left;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        step_end_c      = 1'b0;
        capture_c       = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (run) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                capture_c = (cnt == CNT_SETTLE);
                if (cnt == CNT_LAST) begin
                    step_end_c = 1'b1;
                    cnt_next   = '0;
                    if (!run) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
        endcase
        frame_done_c    = capture_c && (game_sel == 2'd3);
        load_c          = frame_done_c && (!snap_valid || snap_ready);
        // game_clk is registered from the next phase so it never glitches.
        game_clk_next_c = (state_next == STEP) && (cnt_next < CNT_HALF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            game_clk   <= 1'b0;
            game_sel   <= 2'd0;
            step_count <= 16'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            game_clk <= game_clk_next_c;
            if (step_end_c) begin
                game_sel   <= game_sel + 2'd1;
                step_count <= step_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_x    <= 8'd0;
            shadow_y    <= 8'd0;
            shadow_left <= 8'd0;
        end else if (capture_c) begin
            case (game_sel)
                2'd0:    shadow_x    <= game_data;
                2'd1:    shadow_y    <= game_data;
                2'd2:    shadow_left <= game_data;
                default: ;
            endcase
        end
    end

    // Snapshot handshake: a frame arriving with an unconsumed snapshot is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_ball_x <= 8'd0;
            snap_ball_y <= 8'd0;
            snap_left   <= 8'd0;
            snap_right  <= 8'd0;
            snap_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load_c) begin
                snap_ball_x <= shadow_x;
                snap_ball_y <= shadow_y;
                snap_left   <= shadow_left;
                snap_right  <= game_data;
                snap_valid  <= 1'b1;
            end else if (frame_done_c) begin
                overrun <= 1'b1;
            end else if (snap_valid && snap_ready) begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pong_state_reader.sv
// Bench for pong_state_reader: directed phase table, a step waveform sequence,
// and randomized run/ready/reset traffic checked against a step-level model.
module tb_pong_state_reader;

    localparam int unsigned STEP_DIV = 8;
    localparam int unsigned SETTLE   = 2;
    localparam int unsigned NVEC     = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        game_clk;
    logic [1:0]  game_sel;
    logic [7:0]  game_data = 8'd0;
    logic [7:0]  snap_ball_x, snap_ball_y, snap_left, snap_right;
    logic        snap_valid;
    logic        snap_ready = 1'b0;
    logic        overrun;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    pong_state_reader #(.STEP_DIV(STEP_DIV), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .run(run),
        .game_clk(game_clk), .game_sel(game_sel), .game_data(game_data),
        .snap_ball_x(snap_ball_x), .snap_ball_y(snap_ball_y),
        .snap_left(snap_left), .snap_right(snap_right),
        .snap_valid(snap_valid), .snap_ready(snap_ready),
        .overrun(overrun), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Game core model: latch a field byte on each game_clk rise.
    logic [7:0] base = 8'h10;
    bit         scramble = 1'b0;
    logic       gc_q = 1'b0;
    always @(posedge clk) begin
        gc_q <= game_clk;
        if (game_clk && !gc_q)
            game_data <= scramble ? 8'($urandom) : base + 8'(game_sel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within a step as plain integers.
    bit         m_on = 1'b0;
    bit         m_busy, m_valid, m_ovr, m_frame;
    int         m_t, m_sel, m_steps;
    logic [7:0] m_shadow [4];
    logic [7:0] m_snap   [4];

    always @(posedge clk) begin
        m_frame = 1'b0;
        if (reset) begin
            m_on = 1'b1; m_busy = 1'b0; m_t = 0; m_sel = 0; m_steps = 0;
            m_valid = 1'b0; m_ovr = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_shadow[k] = 8'd0;
                m_snap[k]   = 8'd0;
            end
        end else begin
            if (m_busy && m_t == int'(SETTLE)) begin
                m_shadow[m_sel] = game_data;
                m_frame = (m_sel == 3);
            end
            if (m_frame) begin
                if (!m_valid || snap_ready) begin
                    for (int k = 0; k < 4; k++) m_snap[k] = m_shadow[k];
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && snap_ready) begin
                m_valid = 1'b0;
            end
            if (m_busy) begin
                if (m_t == int'(STEP_DIV) - 1) begin
                    m_t = 0;
                    m_sel = (m_sel + 1) % 4;
                    m_steps = (m_steps + 1) % 65536;
                    m_busy = run;
                end else begin
                    m_t++;
                end
            end else if (run) begin
                m_busy = 1'b1;
                m_t = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model.game_clk", 32'(game_clk), 32'(m_busy && m_t < int'(STEP_DIV / 2)));
            chk("model.game_sel", 32'(game_sel), 32'(m_sel));
            chk("model.snap", {snap_ball_x, snap_ball_y, snap_left, snap_right},
                {m_snap[0], m_snap[1], m_snap[2], m_snap[3]});
            chk("model.snap_valid", 32'(snap_valid), 32'(m_valid));
            chk("model.overrun", 32'(overrun), 32'(m_ovr));
            chk("model.step_count", 32'(step_count), 32'(m_steps));
        end
    end

    typedef struct {
        bit          rst, run, rdy;
        logic [7:0]  base;
        int          n;
        bit          gclk;
        logic [1:0]  sel;
        bit          v, o;
        logic [15:0] st;
        logic [31:0] snap;
    } vec_t;

    vec_t vt [NVEC];

    function automatic vec_t mk(bit rst, bit rn, bit rdy, logic [7:0] b, int n,
                                bit gc, logic [1:0] sel, bit v, bit o,
                                logic [15:0] st, logic [31:0] snap);
        vec_t r;
        r.rst = rst; r.run = rn; r.rdy = rdy; r.base = b; r.n = n;
        r.gclk = gc; r.sel = sel; r.v = v; r.o = o; r.st = st; r.snap = snap;
        return r;
    endfunction

    initial begin
        //          rst run rdy base  n   gclk sel v o st  snap
        vt[0]  = mk(1, 0, 0, 8'h10, 2,  0, 0, 0, 0, 0,  32'h0);
        vt[1]  = mk(0, 0, 0, 8'h10, 20, 0, 0, 0, 0, 0,  32'h0);
        vt[2]  = mk(0, 1, 0, 8'h10, 1,  1, 0, 0, 0, 0,  32'h0);
        vt[3]  = mk(0, 1, 0, 8'h10, 4,  0, 0, 0, 0, 0,  32'h0);
        vt[4]  = mk(0, 1, 0, 8'h10, 4,  1, 1, 0, 0, 1,  32'h0);
        vt[5]  = mk(0, 1, 0, 8'h10, 19, 1, 3, 1, 0, 3,  32'h10111213);
        vt[6]  = mk(0, 1, 0, 8'h10, 5,  1, 0, 1, 0, 4,  32'h10111213);
        vt[7]  = mk(0, 1, 0, 8'h20, 27, 1, 3, 1, 1, 7,  32'h10111213);
        vt[8]  = mk(0, 1, 1, 8'h30, 1,  0, 3, 0, 1, 7,  32'h10111213);
        vt[9]  = mk(0, 1, 0, 8'h30, 31, 1, 3, 1, 1, 11, 32'h30313233);
        vt[10] = mk(0, 1, 0, 8'h40, 31, 1, 3, 1, 1, 15, 32'h30313233);
        vt[11] = mk(0, 1, 1, 8'h40, 1,  1, 3, 1, 1, 15, 32'h40414243);
        vt[12] = mk(0, 1, 0, 8'h40, 16, 1, 1, 1, 1, 17, 32'h40414243);
        vt[13] = mk(0, 0, 0, 8'h40, 1,  0, 1, 1, 1, 17, 32'h40414243);
        vt[14] = mk(0, 0, 0, 8'h40, 3,  0, 1, 1, 1, 17, 32'h40414243);
        vt[15] = mk(0, 0, 0, 8'h40, 1,  0, 2, 1, 1, 18, 32'h40414243);
        vt[16] = mk(0, 0, 1, 8'h40, 10, 0, 2, 0, 1, 18, 32'h40414243);
        vt[17] = mk(0, 1, 0, 8'h50, 1,  1, 2, 0, 1, 18, 32'h40414243);
        vt[18] = mk(0, 1, 0, 8'h50, 11, 1, 3, 1, 1, 19, 32'h40415253);
        vt[19] = mk(0, 1, 0, 8'h50, 6,  1, 0, 1, 1, 20, 32'h40415253);
        vt[20] = mk(1, 1, 0, 8'h50, 1,  0, 0, 0, 0, 0,  32'h0);
        vt[21] = mk(0, 0, 0, 8'h50, 5,  0, 0, 0, 0, 0,  32'h0);

        for (int i = 0; i < int'(NVEC); i++) begin
            reset = vt[i].rst; run = vt[i].run; snap_ready = vt[i].rdy; base = vt[i].base;
            repeat (vt[i].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.game_clk", i), 32'(game_clk), 32'(vt[i].gclk));
            chk($sformatf("vec%0d.game_sel", i), 32'(game_sel), 32'(vt[i].sel));
            chk($sformatf("vec%0d.snap_valid", i), 32'(snap_valid), 32'(vt[i].v));
            chk($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(vt[i].o));
            chk($sformatf("vec%0d.step_count", i), 32'(step_count), 32'(vt[i].st));
            chk($sformatf("vec%0d.snap", i), {snap_ball_x, snap_ball_y, snap_left, snap_right},
                vt[i].snap);
        end

        // Two full steps of game_clk: 4 high then 4 low, starting the cycle after run.
        reset = 1'b1; run = 1'b0; snap_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0; run = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("duty.c%0d", c), 32'(game_clk), 32'((c % 8) < 4));
        end

        // Randomized traffic against the model.
        scramble = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 299) == 0);
            run        = ($urandom_range(0, 9) < 8);
            snap_ready = ($urandom_range(0, 9) < 3);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
